// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: h/v counters, look-ahead pixel requests,
// and a fixed-latency output stage that re-aligns sync/blank with returned colour.
module vga_timing_gen #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter bit          H_POL    = 1'b0,
   parameter bit          V_POL    = 1'b0,
   parameter int unsigned COLOR_W  = 10,
   parameter int unsigned PIPE     = 1
) (
   input  logic               iCLK,
   input  logic               iRST_N,
   input  logic               iEN,
   input  logic [COLOR_W-1:0] iRed,
   input  logic [COLOR_W-1:0] iGreen,
   input  logic [COLOR_W-1:0] iBlue,
   output logic [11:0]        px,
   output logic [11:0]        py,
   output logic               oReq,
   output logic               oLine,
   output logic               oFrame,
   output logic [COLOR_W-1:0] VGA_R,
   output logic [COLOR_W-1:0] VGA_G,
   output logic [COLOR_W-1:0] VGA_B,
   output logic               VGA_H_SYNC,
   output logic               VGA_V_SYNC,
   output logic               VGA_BLANK,
   output logic               VGA_SYNC
);

   localparam int unsigned CNT_W   = 12;
   localparam int unsigned ST_W    = 3;
   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W:0]   H_ACT    = (CNT_W+1)'(H_ACTIVE);
   localparam logic [CNT_W:0]   V_ACT    = (CNT_W+1)'(V_ACTIVE);
   localparam logic [CNT_W:0]   HS_START = (CNT_W+1)'(H_ACTIVE + H_FP);
   localparam logic [CNT_W:0]   HS_END   = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W:0]   VS_START = (CNT_W+1)'(V_ACTIVE + V_FP);
   localparam logic [CNT_W:0]   VS_END   = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);

   logic [CNT_W-1:0] h_q, v_q;
   logic [CNT_W-1:0] h_d, v_d;
   logic [CNT_W:0]   h_x, v_x;
   logic             running_c;
   logic             req_c, hs_c, vs_c;
   logic [ST_W-1:0]  stage_c;
   logic [ST_W-1:0]  dly_c;

   // Reset held also silences the request-domain pulses.
   assign running_c = iEN & iRST_N;

   // Counter next-state; idle enable parks both counters at the origin.
   always_comb begin
      h_d = h_q;
      v_d = v_q;
      if (!iEN) begin
         h_d = '0;
         v_d = '0;
      end else if (h_q == H_LAST) begin
         h_d = '0;
         v_d = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
      end else begin
         h_d = h_q + CNT_W'(1);
      end
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         h_q <= '0;
         v_q <= '0;
      end else begin
         h_q <= h_d;
         v_q <= v_d;
      end
   end

   // Extra bit keeps interval limits exact when an interval ends at 4096.
   assign h_x = {1'b0, h_q};
   assign v_x = {1'b0, v_q};

   assign req_c = running_c & (h_x < H_ACT) & (v_x < V_ACT);
   assign hs_c  = running_c & (h_x >= HS_START) & (h_x < HS_END);
   assign vs_c  = running_c & (v_x >= VS_START) & (v_x < VS_END);

   assign px     = h_q;
   assign py     = v_q;
   assign oReq   = req_c;
   assign oLine  = running_c & (h_q == '0) & (v_x < V_ACT);
   assign oFrame = running_c & (h_q == '0) & (v_q == '0);

   assign stage_c = {req_c, hs_c, vs_c};

   // Delay line matching the pixel source latency.
   if (PIPE == 0) begin : g_nopipe
      assign dly_c = stage_c;
   end else begin : g_pipe
      logic [ST_W-1:0] sr_q [PIPE];

      always_ff @(posedge iCLK or negedge iRST_N) begin
         if (!iRST_N) begin
            for (int unsigned i = 0; i < PIPE; i++) sr_q[i] <= '0;
         end else begin
            sr_q[0] <= stage_c;
            for (int unsigned i = 1; i < PIPE; i++) sr_q[i] <= sr_q[i-1];
         end
      end

      assign dly_c = sr_q[PIPE-1];
   end

   // Pin register: colour, blank and syncs leave together.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         VGA_R      <= '0;
         VGA_G      <= '0;
         VGA_B      <= '0;
         VGA_BLANK  <= 1'b0;
         VGA_H_SYNC <= ~H_POL;
         VGA_V_SYNC <= ~V_POL;
      end else begin
         VGA_R      <= dly_c[2] ? iRed   : '0;
         VGA_G      <= dly_c[2] ? iGreen : '0;
         VGA_B      <= dly_c[2] ? iBlue  : '0;
         VGA_BLANK  <= dly_c[2];
         VGA_H_SYNC <= dly_c[1] ? H_POL : ~H_POL;
         VGA_V_SYNC <= dly_c[0] ? V_POL : ~V_POL;
      end
   end

   assign VGA_SYNC = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: four generator configurations (PIPE 1/0/3 with polarity, small mode)
// driven from shared clock, reset and enable, checked against hand-derived values.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   logic rst_n;
   logic en;

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // default mode, PIPE=1
   logic [11:0] px_d, py_d;
   logic        req_d, line_d, frame_d, hs_d, vs_d, blank_d, sync_d;
   logic [9:0]  r_d, g_d, b_d, src_d;
   // default mode, PIPE=0
   logic [11:0] px_0, py_0;
   logic        req_0, line_0, frame_0, hs_0, vs_0, blank_0, sync_0;
   logic [9:0]  r_0, g_0, b_0, src_0;
   // default mode, PIPE=3, positive syncs
   logic [11:0] px_3, py_3;
   logic        req_3, line_3, frame_3, hs_3, vs_3, blank_3, sync_3;
   logic [9:0]  r_3, g_3, b_3;
   logic [9:0]  src_3 [3];
   // small mode, PIPE=1
   logic [11:0] px_s, py_s;
   logic        req_s, line_s, frame_s, hs_s, vs_s, blank_s, sync_s;
   logic [9:0]  r_s, g_s, b_s, src_s;

   // pixel sources: red = x, returned after each instance's latency
   always @(posedge clk) begin
      src_d    <= px_d[9:0];
      src_s    <= px_s[9:0];
      src_3[0] <= px_3[9:0];
      src_3[1] <= src_3[0];
      src_3[2] <= src_3[1];
   end
   assign src_0 = px_0[9:0];

   vga_timing_gen u_def (
      .iCLK(clk), .iRST_N(rst_n), .iEN(en),
      .iRed(src_d), .iGreen(src_d), .iBlue(10'h155),
      .px(px_d), .py(py_d), .oReq(req_d), .oLine(line_d), .oFrame(frame_d),
      .VGA_R(r_d), .VGA_G(g_d), .VGA_B(b_d),
      .VGA_H_SYNC(hs_d), .VGA_V_SYNC(vs_d), .VGA_BLANK(blank_d), .VGA_SYNC(sync_d));

   vga_timing_gen #(.PIPE(0)) u_p0 (
      .iCLK(clk), .iRST_N(rst_n), .iEN(en),
      .iRed(src_0), .iGreen(src_0), .iBlue(10'h2AA),
      .px(px_0), .py(py_0), .oReq(req_0), .oLine(line_0), .oFrame(frame_0),
      .VGA_R(r_0), .VGA_G(g_0), .VGA_B(b_0),
      .VGA_H_SYNC(hs_0), .VGA_V_SYNC(vs_0), .VGA_BLANK(blank_0), .VGA_SYNC(sync_0));

   vga_timing_gen #(.PIPE(3), .H_POL(1'b1), .V_POL(1'b1)) u_p3 (
      .iCLK(clk), .iRST_N(rst_n), .iEN(en),
      .iRed(src_3[2]), .iGreen(src_3[2]), .iBlue(10'h0F0),
      .px(px_3), .py(py_3), .oReq(req_3), .oLine(line_3), .oFrame(frame_3),
      .VGA_R(r_3), .VGA_G(g_3), .VGA_B(b_3),
      .VGA_H_SYNC(hs_3), .VGA_V_SYNC(vs_3), .VGA_BLANK(blank_3), .VGA_SYNC(sync_3));

   vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)) u_sm (
      .iCLK(clk), .iRST_N(rst_n), .iEN(en),
      .iRed(src_s), .iGreen(src_s), .iBlue(10'h001),
      .px(px_s), .py(py_s), .oReq(req_s), .oLine(line_s), .oFrame(frame_s),
      .VGA_R(r_s), .VGA_G(g_s), .VGA_B(b_s),
      .VGA_H_SYNC(hs_s), .VGA_V_SYNC(vs_s), .VGA_BLANK(blank_s), .VGA_SYNC(sync_s));

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // expected red pin in 640x480 timing, t cycles after release, pin latency lat
   function automatic int exp_red(input int t, input int lat);
      int s;
      s = t - lat;
      if (s < 0) return 0;
      if ((s % 800) < 640 && (s / 800) < 480) return s % 800;
      return 0;
   endfunction

   int  mis_d, mis_0, mis_3, mis_b;
   int  hs_lo_d, hs_lo_0, hs_hi_3, bl_d, bl_0, bl_3;
   int  fall1_d, fall2_d, fall_0, rise_3;
   int  hs_lo_s, vs_lo_s, bl_s, frm_s, ln_s, vfall_s;
   logic prev_hs_d, prev_hs_0, prev_hs_3, prev_vs_s;

   initial begin
      rst_n = 1'b1;
      en    = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      // async reset, before any clock edge
      chk("rst_px", px_d, 0);
      chk("rst_py", py_d, 0);
      chk("rst_frame_gated", frame_d, 0);
      chk("rst_line_gated", line_d, 0);
      chk("rst_req_gated", req_d, 0);
      chk("rst_blank", blank_d, 0);
      chk("rst_red", r_d, 0);
      chk("rst_hs_def", hs_d, 1);
      chk("rst_vs_def", vs_d, 1);
      chk("rst_hs_pol1", hs_3, 0);
      chk("rst_vs_pol1", vs_3, 0);
      chk("rst_vga_sync", sync_d, 0);
      tick();
      tick();
      chk("rst_hold_px", px_d, 0);
      chk("rst_hold_hs", hs_d, 1);

      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("first_frame_pulse", frame_d, 1);
      chk("first_line_pulse", line_d, 1);
      chk("first_req", req_d, 1);

      mis_d = 0; mis_0 = 0; mis_3 = 0; mis_b = 0;
      hs_lo_d = 0; hs_lo_0 = 0; hs_hi_3 = 0; bl_d = 0; bl_0 = 0; bl_3 = 0;
      fall1_d = -1; fall2_d = -1; fall_0 = -1; rise_3 = -1;
      hs_lo_s = 0; vs_lo_s = 0; bl_s = 0; frm_s = 0; ln_s = 0; vfall_s = -1;
      prev_hs_d = 1'b1; prev_hs_0 = 1'b1; prev_hs_3 = 1'b0; prev_vs_s = 1'b1;

      // two default lines, ~16 small frames
      for (int t = 0; t < 1600; t++) begin
         if (int'(r_d) != exp_red(t, 2)) mis_d++;
         if (int'(r_0) != exp_red(t, 1)) mis_0++;
         if (int'(r_3) != exp_red(t, 4)) mis_3++;
         if (b_d != (blank_d ? 10'h155 : 10'h000)) mis_b++;
         if (!hs_d) hs_lo_d++;
         if (!hs_0) hs_lo_0++;
         if (hs_3)  hs_hi_3++;
         if (blank_d) bl_d++;
         if (blank_0) bl_0++;
         if (blank_3) bl_3++;
         if (prev_hs_d && !hs_d) begin
            if (fall1_d < 0) fall1_d = t;
            else if (fall2_d < 0) fall2_d = t;
         end
         if (prev_hs_0 && !hs_0 && fall_0 < 0) fall_0 = t;
         if (!prev_hs_3 && hs_3 && rise_3 < 0) rise_3 = t;
         if (!hs_s) hs_lo_s++;
         if (!vs_s) vs_lo_s++;
         if (blank_s) bl_s++;
         if (frame_s) frm_s++;
         if (line_s) ln_s++;
         if (prev_vs_s && !vs_s && vfall_s < 0) vfall_s = t;
         prev_hs_d = hs_d; prev_hs_0 = hs_0; prev_hs_3 = hs_3; prev_vs_s = vs_s;

         if (t == 799) begin
            chk("def_h_last_px", px_d, 799);
            chk("def_h_last_py", py_d, 0);
         end
         if (t == 800) begin
            chk("def_h_wrap_px", px_d, 0);
            chk("def_h_wrap_py", py_d, 1);
            chk("def_line2_pulse", line_d, 1);
            chk("def_line2_noframe", frame_d, 0);
         end
         if (t == 14) begin
            chk("sm_hwrap_px", px_s, 0);
            chk("sm_hwrap_py", py_s, 1);
         end
         if (t == 97) begin
            chk("sm_last_px", px_s, 13);
            chk("sm_last_py", py_s, 6);
            chk("sm_last_noframe", frame_s, 0);
         end
         if (t == 98) begin
            chk("sm_wrap_px", px_s, 0);
            chk("sm_wrap_py", py_s, 0);
            chk("sm_wrap_frame", frame_s, 1);
         end
         tick();
      end

      chk("def_red_track_mismatches", mis_d, 0);
      chk("p0_red_track_mismatches", mis_0, 0);
      chk("p3_red_track_mismatches", mis_3, 0);
      chk("def_blue_gate_mismatches", mis_b, 0);
      chk("def_hs_low_cycles", hs_lo_d, 192);
      chk("def_hs_fall1", fall1_d, 658);
      chk("def_hs_period", fall2_d - fall1_d, 800);
      chk("def_blank_cycles", bl_d, 1280);
      chk("p0_hs_low_cycles", hs_lo_0, 192);
      chk("p0_hs_fall1", fall_0, 657);
      chk("p0_blank_cycles", bl_0, 1280);
      chk("p3_hs_high_cycles", hs_hi_3, 192);
      chk("p3_hs_rise1", rise_3, 660);
      chk("p3_blank_cycles", bl_3, 1280);
      chk("p3_vs_idle", vs_3, 0);
      chk("sm_hs_low_cycles", hs_lo_s, 228);
      chk("sm_vs_low_cycles", vs_lo_s, 224);
      chk("sm_vs_fall1", vfall_s, 72);
      chk("sm_blank_cycles", bl_s, 530);
      chk("sm_frame_pulses", frm_s, 17);
      chk("sm_line_pulses", ln_s, 67);

      // enable dropped at h=300 of line 2
      repeat (300) tick();
      chk("pre_drop_px", px_d, 300);
      chk("pre_drop_py", py_d, 2);
      en = 1'b0;
      #1;
      chk("drop_req_now", req_d, 0);
      tick();
      chk("drop_px_zero", px_d, 0);
      chk("drop_py_zero", py_d, 0);
      chk("drop_blank_still_1", blank_d, 1);
      tick();
      chk("drop_blank_after2", blank_d, 0);
      chk("drop_red_after2", r_d, 0);
      chk("drop_hs_idle", hs_d, 1);
      chk("drop_vs_idle", vs_d, 1);
      chk("drop_p3_blank_still_1", blank_3, 1);
      tick();
      tick();
      chk("drop_p3_blank_after4", blank_3, 0);
      chk("drop_hold_px", px_d, 0);

      en = 1'b1;
      #1;
      chk("rise_frame_def", frame_d, 1);
      chk("rise_frame_sm", frame_s, 1);
      chk("rise_req_def", req_d, 1);
      tick();
      chk("rise_px_step", px_d, 1);
      chk("rise_frame_gone", frame_d, 0);
      repeat (49) tick();
      chk("rerun_red_at_50", r_d, 48);
      chk("rerun_blank_at_50", blank_d, 1);

      // asynchronous reset mid-line, between clock edges
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_px", px_d, 0);
      chk("arst_blank", blank_d, 0);
      chk("arst_red", r_d, 0);
      chk("arst_hs_def", hs_d, 1);
      chk("arst_hs_pol1", hs_3, 0);
      chk("arst_frame_gated", frame_d, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rel_frame", frame_d, 1);
      tick();
      chk("rel_px1", px_d, 1);
      chk("rel_blank_flushed", blank_d, 0);
      tick();
      chk("rel_blank_at2", blank_d, 1);
      chk("rel_red_x0", r_d, 0);
      tick();
      chk("rel_red_x1", r_d, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
